coin_acceptor: RTL and testbench



---
 rtl/coin_acceptor.sv | 190 +++++++++++++++++++
 tb/tb_coin_acceptor.sv | 188 ++++++++++++++++++
 2 files changed

// File: rtl/coin_acceptor.sv
// Purpose : conditions the raw coin-sense line, measures pulse width and
//           classifies it into a one-hot coin code with a ModeEnable strobe.
// Latency : ModeEnable/Reject fire 2+DEBOUNCE+1 cycles after the raw falling edge.
// Backpressure: no handshake; Busy (sampled only at the decision cycle) refuses
//           a valid coin with Reject, and coins arriving during lockout are dropped.
//
// Ports:
//   Clk        in   system clock, rising edge
//   nReset     in   asynchronous active-low reset
//   CoinSense  in   raw mechanism line, asynchronous, high while a coin passes
//   Busy       in   charging session running; valid coins are refused
//   Coin       out  one-hot code 001=1, 010=5, 100=10; 000 unless ModeEnable
//   ModeEnable out  single-cycle strobe qualifying Coin
//   Reject     out  single-cycle pulse, coin returned
//   Jam        out  level, high while the mechanism is stuck high
module coin_acceptor #(
  parameter int CNT_W    = 8,
  parameter int DEBOUNCE = 4,
  parameter int P1_MIN   = 8,
  parameter int P1_MAX   = 15,
  parameter int P5_MIN   = 20,
  parameter int P5_MAX   = 31,
  parameter int P10_MIN  = 40,
  parameter int P10_MAX  = 63,
  parameter int TIMEOUT  = 128,
  parameter int GAP      = 16
) (
  input  logic       Clk,
  input  logic       nReset,
  input  logic       CoinSense,
  input  logic       Busy,
  output logic [2:0] Coin,
  output logic       ModeEnable,
  output logic       Reject,
  output logic       Jam
);

  localparam logic [CNT_W-1:0] DB_LAST  = CNT_W'(DEBOUNCE - 1);
  localparam logic [CNT_W-1:0] P1_LO    = CNT_W'(P1_MIN);
  localparam logic [CNT_W-1:0] P1_HI    = CNT_W'(P1_MAX);
  localparam logic [CNT_W-1:0] P5_LO    = CNT_W'(P5_MIN);
  localparam logic [CNT_W-1:0] P5_HI    = CNT_W'(P5_MAX);
  localparam logic [CNT_W-1:0] P10_LO   = CNT_W'(P10_MIN);
  localparam logic [CNT_W-1:0] P10_HI   = CNT_W'(P10_MAX);
  localparam logic [CNT_W-1:0] TO_W     = CNT_W'(TIMEOUT);
  localparam logic [CNT_W-1:0] GAP_LAST = CNT_W'(GAP - 1);

  typedef enum logic [2:0] {
    WAIT_LOW = 3'd0,
    IDLE     = 3'd1,
    MEASURE  = 3'd2,
    DECIDE   = 3'd3,
    LOCKOUT  = 3'd4
  } state_t;

  // ---------------------------------------------------------------------
  // Input conditioning: two-flop synchronizer followed by a symmetric
  // debounce filter. Both edges see the same delay, so the filtered pulse
  // width equals the raw width for clean pulses.
  // ---------------------------------------------------------------------
  logic             sense_meta;
  logic             sense_sync;
  logic             filt;
  logic [CNT_W-1:0] db_cnt;

  always_ff @(posedge Clk or negedge nReset) begin
    if (!nReset) begin
      sense_meta <= 1'b0;
      sense_sync <= 1'b0;
      filt       <= 1'b0;
      db_cnt     <= '0;
    end else begin
      sense_meta <= CoinSense;
      sense_sync <= sense_meta;
      if (sense_sync == filt) begin
        db_cnt <= '0;
      end else if (db_cnt == DB_LAST) begin
        // DEBOUNCE consecutive disagreeing cycles seen: accept the new level
        filt   <= sense_sync;
        db_cnt <= '0;
      end else begin
        db_cnt <= db_cnt + 1'b1;
      end
    end
  end

  // ---------------------------------------------------------------------
  // Width classification, inclusive bounds.
  // ---------------------------------------------------------------------
  function automatic logic [2:0] band_of(input logic [CNT_W-1:0] w);
    logic [2:0] code;
    code = 3'b000;
    if (w >= P1_LO && w <= P1_HI)        code = 3'b001;
    else if (w >= P5_LO && w <= P5_HI)   code = 3'b010;
    else if (w >= P10_LO && w <= P10_HI) code = 3'b100;
    return code;
  endfunction

  // ---------------------------------------------------------------------
  // Control FSM
  // ---------------------------------------------------------------------
  state_t           state, state_nxt;
  logic [CNT_W-1:0] width, width_nxt;
  logic [CNT_W-1:0] gap_cnt, gap_nxt;
  logic [2:0]       band_q, band_nxt;
  logic             jam_q, jam_nxt;

  always_ff @(posedge Clk or negedge nReset) begin
    if (!nReset) begin
      state   <= WAIT_LOW;
      width   <= '0;
      gap_cnt <= '0;
      band_q  <= 3'b000;
      jam_q   <= 1'b0;
    end else begin
      state   <= state_nxt;
      width   <= width_nxt;
      gap_cnt <= gap_nxt;
      band_q  <= band_nxt;
      jam_q   <= jam_nxt;
    end
  end

  always_comb begin
    state_nxt  = state;
    width_nxt  = width;
    gap_nxt    = gap_cnt;
    band_nxt   = band_q;
    jam_nxt    = jam_q;
    Coin       = 3'b000;
    ModeEnable = 1'b0;
    Reject     = 1'b0;
    // Jam stays up after a timeout only while the line is still held high
    Jam        = jam_q & filt;

    if (!filt) jam_nxt = 1'b0;

    case (state)
      WAIT_LOW: begin
        if (!filt) state_nxt = IDLE;
      end

      IDLE: begin
        // IDLE is only ever entered with filt low, so filt high here is a rising edge
        if (filt) begin
          state_nxt = MEASURE;
          width_nxt = CNT_W'(1);
        end
      end

      MEASURE: begin
        if (width == TO_W) begin
          // Timeout takes priority; width never counts past TIMEOUT
          Reject    = 1'b1;
          Jam       = 1'b1;
          jam_nxt   = 1'b1;
          state_nxt = WAIT_LOW;
        end else if (filt) begin
          width_nxt = width + 1'b1;
        end else begin
          band_nxt  = band_of(width);
          state_nxt = DECIDE;
        end
      end

      DECIDE: begin
        if (band_q != 3'b000 && !Busy) begin
          Coin       = band_q;
          ModeEnable = 1'b1;
        end else begin
          Reject     = 1'b1;
        end
        gap_nxt   = '0;
        state_nxt = LOCKOUT;
      end

      LOCKOUT: begin
        if (gap_cnt == GAP_LAST) begin
          // A coin still present at the end of lockout is discarded via WAIT_LOW
          state_nxt = filt ? WAIT_LOW : IDLE;
        end else begin
          gap_nxt = gap_cnt + 1'b1;
        end
      end

      default: state_nxt = WAIT_LOW;
    endcase
  end

endmodule

// File: tb/tb_coin_acceptor.sv
// Bench for coin_acceptor: directed and random raw pulse trains, with the
// expected per-cycle outputs computed from a pulse-timeline model.
module tb_coin_acceptor;

  localparam int DEBOUNCE = 4;
  localparam int TIMEOUT  = 128;
  localparam int GAP      = 16;
  localparam int LAT      = 2 + DEBOUNCE;   // raw edge -> filtered edge
  localparam int NCYC     = 12000;

  logic       Clk = 1'b0;
  logic       nReset;
  logic       CoinSense;
  logic       Busy;
  logic [2:0] Coin;
  logic       ModeEnable;
  logic       Reject;
  logic       Jam;

  coin_acceptor dut (
    .Clk       (Clk),
    .nReset    (nReset),
    .CoinSense (CoinSense),
    .Busy      (Busy),
    .Coin      (Coin),
    .ModeEnable(ModeEnable),
    .Reject    (Reject),
    .Jam       (Jam)
  );

  always #5 Clk = ~Clk;

  typedef struct {
    int s;
    int w;
    bit killed;
  } pulse_t;

  pulse_t     pq[$];
  bit         raw_arr  [NCYC];
  bit         busy_arr [NCYC];
  logic [5:0] exp_arr  [NCYC];   // {ModeEnable, Reject, Jam, Coin}

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int cur   = 0;
  int rk_lo = -1;
  int rk_hi = -1;
  int t_end = 0;

  task automatic chk(input string tag, input logic [5:0] obs, input logic [5:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s cyc=%0d got me/rej/jam/coin=%b want=%b", tag, cyc, obs, exp);
    end
  endtask

  task automatic put(input int gap, input int w, input bit killed);
    pulse_t p;
    cur += gap;
    p.s = cur; p.w = w; p.killed = killed;
    pq.push_back(p);
    for (int c = cur; c < cur + w; c++) raw_arr[c] = 1'b1;
    cur += w;
  endtask

  function automatic logic [2:0] band_of(input int w);
    if (w >= 8 && w <= 15)  return 3'b001;
    if (w >= 20 && w <= 31) return 3'b010;
    if (w >= 40 && w <= 63) return 3'b100;
    return 3'b000;
  endfunction

  // Timeline model: each clean pulse appears on the filtered line LAT cycles
  // later with the same width. 'ready' is the first cycle the acceptor can
  // take a new rising edge; 'lock_x' is the last lockout cycle, where a
  // still-high line sends the acceptor to wait for the line to drop.
  task automatic build_expect();
    int ready, lock_x, r, f, t, d, jend;
    logic [2:0] code;
    for (int c = 0; c < NCYC; c++) exp_arr[c] = 6'b0;
    ready  = 4;
    lock_x = -1;
    foreach (pq[i]) begin
      if (pq[i].killed) begin
        ready  = rk_hi + 2;
        lock_x = -1;
        continue;
      end
      if (pq[i].w < DEBOUNCE) continue;
      r = pq[i].s + LAT;
      f = r + pq[i].w;
      if (r >= ready) begin
        if (pq[i].w >= TIMEOUT) begin
          t    = r + TIMEOUT;
          jend = (f > t + 1) ? f : t + 1;
          exp_arr[t][4] = 1'b1;
          for (int c = t; c < jend; c++) exp_arr[c][3] = 1'b1;
          ready  = jend + 1;
          lock_x = -1;
        end else begin
          d    = f + 1;
          code = band_of(pq[i].w);
          if (code != 3'b000 && !busy_arr[d]) exp_arr[d] = {1'b1, 1'b0, 1'b0, code};
          else                                exp_arr[d] = {1'b0, 1'b1, 1'b0, 3'b000};
          lock_x = d + GAP;
          ready  = lock_x + 1;
        end
      end else if (lock_x >= 0 && r <= lock_x && lock_x < f) begin
        ready = f + 1;
      end
    end
  endtask

  initial begin
    int edges [15];
    int gap, w, pick, s_busy, s_r, rand_start;
    edges = '{7, 8, 15, 16, 19, 20, 31, 32, 39, 40, 63, 64, 127, 128, 129};

    nReset    = 1'b0;
    CoinSense = 1'b0;
    Busy      = 1'b0;

    // Clean coins of each denomination
    cur = 20;
    put(0, 12, 0);
    put(45, 25, 0);
    put(45, 50, 0);
    // Band edges
    put(45, 7, 0);  put(45, 8, 0);  put(45, 15, 0);
    put(45, 16, 0); put(45, 63, 0); put(45, 64, 0);
    // Noise: short glitch, then single-cycle toggling
    put(45, 3, 0);
    put(20, 1, 0);
    for (int k = 0; k < 4; k++) put(1, 1, 0);
    // Valid 5-coin while busy, then again while idle
    put(45, 25, 0);
    s_busy = cur - 25;
    for (int c = s_busy; c < s_busy + 50; c++) busy_arr[c] = 1'b1;
    put(45, 25, 0);
    // Jam followed by a good coin
    put(45, 300, 0);
    put(45, 12, 0);
    // Reset in the middle of a pulse, released while the line is still high
    put(45, 25, 1);
    s_r   = cur - 25;
    rk_lo = s_r + 16;
    rk_hi = s_r + 22;
    // Good coin, then a second pulse that starts during its lockout
    put(45, 12, 0);
    put(12, 12, 0);

    // Random section with random Busy toggling
    rand_start = cur + 40;
    for (int c = rand_start; c < NCYC; c++) busy_arr[c] = ($urandom_range(0, 3) == 0);
    cur = rand_start;
    for (int i = 0; i < 40; i++) begin
      gap  = $urandom_range(4, 60);
      pick = $urandom_range(0, 9);
      if (pick < 2)      w = $urandom_range(1, 3);
      else if (pick < 6) w = $urandom_range(4, 70);
      else if (pick < 9) w = edges[$urandom_range(0, 14)];
      else               w = $urandom_range(100, 160);
      if (cur + gap + w + 300 >= NCYC) break;
      put(gap, w, 0);
    end
    t_end = cur + 200;

    build_expect();

    for (int c = 0; c < t_end; c++) begin
      @(posedge Clk);
      #1;
      cyc       = c;
      nReset    = !(c < 2 || (c >= rk_lo && c < rk_hi));
      CoinSense = raw_arr[c];
      Busy      = busy_arr[c];
      @(negedge Clk);
      chk(nReset ? "cyc" : "rst", {ModeEnable, Reject, Jam, Coin}, exp_arr[c]);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
